// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU control unit: sequences IF/ID/EXE/MEM/WB and drives every
// datapath control signal from state, opcode, funct and the ALU Zero flag.
//
// state    | meaning
// IF       | fetch; load IR, no other enables
// ID       | decode; j/jal/jr/unknown finish here, HALT_OP parks here
// EXE_LS   | lw/sw address calculation
// MEM      | data memory access; sw finishes here
// WB_LD    | lw writes memory data to rt
// EXE_BR   | beq/bne compare and conditional PC update
// EXE_AL   | R-type / immediate ALU operation
// WB_AL    | ALU result written to rd or rt
module multi_cycle_control (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       Zero,
   output logic [2:0] state,
   output logic       Halted,
   output logic       PCWre,
   output logic       IRWre,
   output logic       InsMemRW,
   output logic       ExtSel,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       mRD,
   output logic       mWR,
   output logic       DBDataSrc,
   output logic       RegWre,
   output logic [1:0] RegDst,
   output logic       WrRegDSrc,
   output logic [1:0] PCSrc
);

   localparam logic [5:0] HALT_OP  = 6'b111111;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;
   localparam logic [5:0] F_SLL = 6'b000000;
   localparam logic [5:0] F_JR  = 6'b001000;

   typedef enum logic [2:0] {
      S_IF     = 3'b000,
      S_ID     = 3'b001,
      S_EXE_LS = 3'b010,
      S_MEM    = 3'b011,
      S_WB_LD  = 3'b100,
      S_EXE_BR = 3'b101,
      S_EXE_AL = 3'b110,
      S_WB_AL  = 3'b111
   } state_t;

   state_t cur_state, nxt_state;

   logic       is_r_alu, is_sll, is_jr, is_imm, is_lw, is_sw;
   logic       is_beq, is_bne, is_j, is_jal, is_known;
   logic [2:0] alu_op_dec;
   logic       halt_set, frozen;

   logic       pc_wre, ir_wre, ins_mem_rw, ext_sel, alu_src_a, alu_src_b;
   logic [2:0] alu_op;
   logic       mem_rd, mem_wr, db_src, reg_wre, wr_src;
   logic [1:0] reg_dst, pc_src;

   always_ff @(posedge CLK) begin
      if (!Reset) begin
         cur_state <= S_IF;
         Halted    <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         if (halt_set) begin
            Halted <= 1'b1;
         end
      end
   end

   assign state = cur_state;

   always_comb begin
      is_r_alu   = 1'b0;
      is_jr      = 1'b0;
      alu_op_dec = 3'b000;
      if (op == OP_RTYPE) begin
         case (funct)
            F_ADD:   begin is_r_alu = 1'b1; alu_op_dec = 3'b000; end
            F_SUB:   begin is_r_alu = 1'b1; alu_op_dec = 3'b001; end
            F_SLL:   begin is_r_alu = 1'b1; alu_op_dec = 3'b010; end
            F_OR:    begin is_r_alu = 1'b1; alu_op_dec = 3'b011; end
            F_AND:   begin is_r_alu = 1'b1; alu_op_dec = 3'b100; end
            F_SLT:   begin is_r_alu = 1'b1; alu_op_dec = 3'b101; end
            F_JR:    is_jr = 1'b1;
            default: ;
         endcase
      end else begin
         case (op)
            OP_ORI:         alu_op_dec = 3'b011;
            OP_SLTI:        alu_op_dec = 3'b101;
            OP_BEQ, OP_BNE: alu_op_dec = 3'b001;
            default:        alu_op_dec = 3'b000;
         endcase
      end
   end

   assign is_sll   = is_r_alu && (funct == F_SLL);
   assign is_imm   = (op == OP_ADDI) || (op == OP_ORI) || (op == OP_SLTI);
   assign is_lw    = (op == OP_LW);
   assign is_sw    = (op == OP_SW);
   assign is_beq   = (op == OP_BEQ);
   assign is_bne   = (op == OP_BNE);
   assign is_j     = (op == OP_J);
   assign is_jal   = (op == OP_JAL);
   assign is_known = is_r_alu | is_imm | is_lw | is_sw | is_beq | is_bne;

   assign halt_set = (cur_state == S_ID) && (op == HALT_OP);
   assign frozen   = Halted | halt_set;

   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         S_IF:     nxt_state = S_ID;
         S_ID: begin
            if (frozen)                  nxt_state = S_ID;
            else if (is_r_alu || is_imm) nxt_state = S_EXE_AL;
            else if (is_lw || is_sw)     nxt_state = S_EXE_LS;
            else if (is_beq || is_bne)   nxt_state = S_EXE_BR;
            else                         nxt_state = S_IF;
         end
         S_EXE_AL: nxt_state = S_WB_AL;
         S_WB_AL:  nxt_state = S_IF;
         S_EXE_BR: nxt_state = S_IF;
         S_EXE_LS: nxt_state = S_MEM;
         S_MEM:    nxt_state = is_lw ? S_WB_LD : S_IF;
         S_WB_LD:  nxt_state = S_IF;
      endcase
   end

   always_comb begin
      pc_wre     = 1'b0;
      ir_wre     = 1'b0;
      ins_mem_rw = 1'b0;
      ext_sel    = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 1'b0;
      alu_op     = 3'b000;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      db_src     = 1'b0;
      reg_wre    = 1'b0;
      reg_dst    = 2'b00;
      wr_src     = 1'b0;
      pc_src     = 2'b00;

      // Datapath fields depend only on the instruction, so they stay put from EXE through WB
      if ((cur_state != S_IF) && (cur_state != S_ID)) begin
         alu_op    = alu_op_dec;
         alu_src_a = is_sll;
         alu_src_b = is_imm | is_lw | is_sw;
         ext_sel   = (is_imm && (op != OP_ORI)) | is_lw | is_sw | is_beq | is_bne;
         db_src    = is_lw;
      end

      case (cur_state)
         S_IF: begin
            ir_wre     = 1'b1;
            ins_mem_rw = 1'b1;
         end
         S_ID: begin
            if (!frozen) begin
               if (is_j) begin
                  pc_wre = 1'b1;
                  pc_src = 2'b11;
               end else if (is_jal) begin
                  pc_wre  = 1'b1;
                  pc_src  = 2'b11;
                  reg_wre = 1'b1;
                  reg_dst = 2'b00;
                  wr_src  = 1'b0;
               end else if (is_jr) begin
                  pc_wre = 1'b1;
                  pc_src = 2'b10;
               end else if (!is_known) begin
                  pc_wre = 1'b1;
               end
            end
         end
         S_EXE_BR: begin
            pc_wre = 1'b1;
            pc_src = ((is_beq && Zero) || (is_bne && !Zero)) ? 2'b01 : 2'b00;
         end
         S_MEM: begin
            mem_rd = is_lw;
            mem_wr = is_sw;
            pc_wre = !is_lw;
         end
         S_WB_AL: begin
            pc_wre  = 1'b1;
            reg_wre = 1'b1;
            reg_dst = is_r_alu ? 2'b10 : 2'b01;
            wr_src  = 1'b1;
         end
         S_WB_LD: begin
            pc_wre  = 1'b1;
            reg_wre = 1'b1;
            reg_dst = 2'b01;
            wr_src  = 1'b1;
         end
         default: ;
      endcase
   end

   // Reset is synchronous, so state may still be mid-instruction while Reset is low
   assign PCWre     = pc_wre & Reset;
   assign IRWre     = ir_wre & Reset;
   assign RegWre    = reg_wre & Reset;
   assign mRD       = mem_rd & Reset;
   assign mWR       = mem_wr & Reset;
   assign InsMemRW  = ins_mem_rw;
   assign ExtSel    = ext_sel;
   assign ALUSrcA   = alu_src_a;
   assign ALUSrcB   = alu_src_b;
   assign ALUOp     = alu_op;
   assign DBDataSrc = db_src;
   assign RegDst    = reg_dst;
   assign WrRegDSrc = wr_src;
   assign PCSrc     = pc_src;

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Multi-cycle control unit for the CPU: a state machine that sequences each instruction through IF/ID/EXE/MEM/WB and produces every datapath control signal. It sits directly upstream of the register file, which it drives through RegWre, RegDst and WrRegDSrc. It also drives PC, IR, instruction memory, ALU, extender and data memory. Opcode and funct come from the registered IR; Zero comes from the ALU.

## Interface
- HALT_OP, 6'b111111, opcode that stops the machine

- CLK  in  1  clock; state register updates on posedge
- Reset  in  1  synchronous, active-low; sampled on posedge CLK
- op  in  6  IR[31:26], registered in IR
- funct  in  6  IR[5:0]
- Zero  in  1  ALU result == 0
- state  out  3  current state: IF=000, ID=001, EXE_LS=010, MEM=011, WB_LD=100, EXE_BR=101, EXE_AL=110, WB_AL=111
- Halted  out  1  sticky halt flag
- PCWre  out  1  PC load enable
- IRWre  out  1  IR load enable
- InsMemRW  out  1  instruction memory read
- ExtSel  out  1  1 = sign extend, 0 = zero extend
- ALUSrcA  out  1  1 = shamt, 0 = rs
- ALUSrcB  out  1  1 = extended immediate, 0 = rt
- ALUOp  out  3  000 add, 001 sub, 010 sll (B<<A), 011 or, 100 and, 101 slt (signed)
- mRD / mWR  out  1 each  data memory read / write
- DBDataSrc  out  1  1 = memory data, 0 = ALU result, onto DB
- RegWre  out  1  register write enable
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd
- WrRegDSrc  out  1  1 = DB, 0 = PC+4
- PCSrc  out  2  00 = PC+4, 01 = PC+4+(simm<<2), 10 = rs (jr), 11 = jump target

## Operation
Supported instructions:
- R-type (op=000000), by funct: add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, jr 001000
- Immediate and memory: addi 001000, ori 001101, slti 001010, lw 100011, sw 101011
- Branch and jump: beq 000100, bne 000101, j 000010, jal 000011

State transitions:
- IF → ID always.
- ID → IF for j, jal, jr, and for unknown opcodes (treated as nop, PC+4).
- ID → EXE_BR for beq/bne; ID → EXE_LS for lw/sw; ID → EXE_AL for ALU ops.
- ID with op == HALT_OP: Halted ← 1 and state stays ID. All enables are 0 from then until Reset.
- EXE_AL → WB_AL → IF.
- EXE_BR → IF.
- EXE_LS → MEM. From MEM: sw → IF, lw → WB_LD → IF.

Output rules (combinational from state, op, funct, Zero):
- In IF, outputs must not depend on op/funct, because IR still holds the previous instruction.
- IF: InsMemRW=1, IRWre=1; all other enables 0.
- PCWre=1 only in an instruction's final state:
  - ID for j/jal/jr/unknown
  - EXE_BR
  - MEM for sw
  - WB_AL
  - WB_LD
- RegWre=1 only in:
  - WB_AL: RegDst=10 for R-type, 01 for immediate ops; WrRegDSrc=1, DBDataSrc=0
  - WB_LD: RegDst=01, WrRegDSrc=1, DBDataSrc=1
  - ID for jal: RegDst=00, WrRegDSrc=0, so $31 ← PC+4
- EXE_BR: ALUOp=001, ALUSrcB=0. PCSrc=01 if (beq & Zero) | (bne & ~Zero), else 00.
- EXE_LS/MEM: ALUOp=000, ALUSrcB=1, ExtSel=1. In MEM, mRD=1 for lw and mWR=1 for sw.
- ExtSel=0 only for ori. ALUSrcA=1 only for sll.
- Hold ALUOp, ALUSrcA/B, ExtSel and DBDataSrc stable from EXE through WB of the same instruction.
- Default for unused fields: 0.

## Timing
- Latency in cycles: j/jal/jr = 2; beq/bne = 3; sw = 4; R-type/immediate = 4; lw = 5.
- The register file writes on negedge CLK, so RegWre/RegDst/WrRegDSrc must be valid from posedge to the following negedge of the WB (or jal ID) cycle.
- PC and IR load on the posedge that ends the cycle in which PCWre/IRWre is 1.
- Reset low at posedge: state ← IF, Halted ← 0. While Reset=0, PCWre, IRWre, RegWre, mRD and mWR are forced 0, including when reset arrives mid-instruction. There are no partial writes after reset.
- The first cycle after Reset goes high is IF.

## Test plan
- Reset held 2 cycles mid-WB_AL → RegWre=0 during reset; state=000 and Halted=0 after; next cycle IRWre=1.
- addi $1,$0,5 then add $3,$1,$2 → states 000,001,110,111 each. RegDst=01 then 10; RegWre=1 only in state 111; PCWre=1 only in 111.
- lw with op=100011 → states 000,001,010,011,100. mRD=1 in 011; RegWre=1, DBDataSrc=1 in 100. sw → 4 cycles, mWR=1 in 011, no RegWre.
- beq with Zero=1 → PCSrc=01 in 101. beq with Zero=0 → PCSrc=00. bne with Zero=0 → PCSrc=01. Each takes 3 cycles.
- jal → ID has RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1. jr → PCSrc=10 and no RegWre.
- op=111111 → Halted=1 and state frozen at 001 with all enables 0 for 20 cycles; Reset low clears Halted.
